requant_q16_16_to_q8_8: RTL and testbench
=========================================

REQUANT_Q16_16_TO_Q8_8 -- requirements
Module: requant_q16_16_to_q8_8

Interface
REQ-001 Parameter ROUND_MODE, default 1, rounding select: 0 = truncate (floor), 1 = round half up (ties toward +inf).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream word valid.
REQ-005 in_ready  output  1  block can accept in_data this cycle.
REQ-006 in_data  input  32  signed Q16.16 (MAC accumulator format).
REQ-007 out_valid  output  1  out_data valid.
REQ-008 out_ready  input  1  downstream accepts out_data.
REQ-009 out_data  output  16  signed Q8.8 result.
REQ-010 out_sat  output  1  out_data was clamped; qualified by out_valid.
REQ-011 clear_count  input  1  synchronous clear of sat_count.
REQ-012 sat_count  output  16  count of saturated words delivered.

Function
REQ-013 Input transfer on in_valid & in_ready; output transfer on out_valid & out_ready.
REQ-014 Two-stage pipeline: S1 registers the rounded sum, S2 registers the saturated Q8.8 value and sat flag.
REQ-015 S1: 33-bit sign-extended in_data, plus 128 when ROUND_MODE=1 (plus 0 when ROUND_MODE=0); no overflow possible.
REQ-016 S2: arithmetic right shift of the S1 value by 8; >32767 -> 0x7FFF with sat=1; <-32768 -> 0x8000 with sat=1; else low 16 bits with sat=0.
REQ-017 Latency: an accepted word appears on out_data exactly 2 cycles later when out_ready is held high; throughput 1 word/cycle.
REQ-018 S2 advances when !S2_valid | out_ready; S1 advances when !S1_valid | S2 advances; in_ready = S1 advances (combinational path out_ready -> in_ready permitted).
REQ-019 While out_valid=1 and out_ready=0: out_data and out_sat stay stable and no word is dropped or duplicated.
REQ-020 Word order is preserved; there are no bubbles when both sides are continuously ready.
REQ-021 sat_count increments by 1 on each output transfer with out_sat=1 and saturates at 0xFFFF (no wrap).
REQ-022 clear_count and an increment in the same cycle: clear wins, sat_count = 0.
REQ-023 in_valid with in_ready=0: the block ignores the input and upstream holds it.

Reset
REQ-024 rst low clears immediately: S1_valid=0, S2_valid=0, out_valid=0, out_data=0x0000, out_sat=0, sat_count=0.
REQ-025 in_ready is 1 in the first cycle after rst deasserts.
REQ-026 Reset mid-stream discards all in-flight words; no partial word emerges after release.

Structure
REQ-027 Shared package npu_fixed_pkg holds: q8_8_t (signed 16), q16_16_t (signed 32), Q8_8_MAX=16'sh7FFF, Q8_8_MIN=16'sh8000, Q_SHIFT=8.
REQ-028 The block has no sub-module; the two stages live in one module.

Verification
REQ-029 ROUND_MODE=1, out_ready=1, back-to-back 0x00010000, 0x00008000 -> 0x0100 then 0x0080, 2 cycles after each input, out_sat=0.
REQ-030 Rounding: 0x00000080 -> 0x0001 (mode 1) / 0x0000 (mode 0); 0xFFFFFF80 -> 0x0000 (mode 1) / 0xFFFF (mode 0).
REQ-031 Saturation edges, mode 1: 0x007FFF7F -> 0x7FFF sat=0; 0x007FFF80 -> 0x7FFF sat=1; 0x3FFF0001 (max x max) -> 0x7FFF sat=1; 0x80000000 -> 0x8000 sat=1; sat_count ends at 3.
REQ-032 Backpressure: stream 5 words, hold out_ready=0 for 4 cycles -> in_ready drops after 2 words are buffered; all 5 outputs arrive in order with out_data stable while stalled.
REQ-033 Counter: saturate 2 words with clear_count pulsed in the same cycle as the 2nd transfer -> sat_count=0; force sat_count to 0xFFFF, then 1 more saturation -> stays 0xFFFF.
REQ-034 Assert rst with 2 words in flight -> out_valid=0 immediately, sat_count=0; after release no stale word appears and in_ready=1.

Source files
------------

// File: rtl/npu_fixed_pkg.sv
// Shared fixed-point types and limits for the NPU datapath.
//   q16_16_t : signed Q16.16 accumulator word
//   q8_8_t   : signed Q8.8 activation word
package npu_fixed_pkg;

   localparam int unsigned Q16_16_W = 32;
   localparam int unsigned Q8_8_W   = 16;
   localparam int unsigned ACC_W    = Q16_16_W + 1;  // room for the rounding add
   localparam int unsigned CNT_W    = 16;
   localparam int unsigned Q_SHIFT  = 8;

   typedef logic signed [Q8_8_W-1:0]   q8_8_t;
   typedef logic signed [Q16_16_W-1:0] q16_16_t;

   localparam q8_8_t Q8_8_MAX = 16'sh7FFF;
   localparam q8_8_t Q8_8_MIN = 16'sh8000;

endpackage

// File: rtl/requant_q16_16_to_q8_8_if.sv
// Valid/ready stream bundle for the requantiser: Q16.16 words in, Q8.8 words
// plus a saturation flag out.
//   master : upstream producer / downstream consumer side
//   slave  : the requantiser itself
interface requant_q16_16_to_q8_8_if;
   import npu_fixed_pkg::*;

   logic    in_valid;
   logic    in_ready;
   q16_16_t in_data;
   logic    out_valid;
   logic    out_ready;
   q8_8_t   out_data;
   logic    out_sat;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_sat
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_sat
   );

endinterface

// File: rtl/requant_q16_16_to_q8_8.sv
// Two-stage requantiser: signed Q16.16 -> signed Q8.8 with optional
// round-half-up and saturation, plus a sticky-at-max saturation counter.
// Ports:
//   clk, rst       : clock, asynchronous active-low reset
//   bus (slave)    : in_valid/in_ready/in_data, out_valid/out_ready/out_data/out_sat
//   clear_count    : synchronous clear of sat_count (wins over an increment)
//   sat_count      : number of saturated words delivered, holds at 0xFFFF
module requant_q16_16_to_q8_8
   import npu_fixed_pkg::*;
#(
   parameter int unsigned ROUND_MODE = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   requant_q16_16_to_q8_8_if.slave   bus,
   input  logic                      clear_count,
   output logic [CNT_W-1:0]          sat_count
);

   localparam logic signed [ACC_W-1:0] RND    = (ROUND_MODE == 1) ? ACC_W'(128) : '0;
   localparam logic signed [ACC_W-1:0] S2_HI  = ACC_W'(Q8_8_MAX);
   localparam logic signed [ACC_W-1:0] S2_LO  = ACC_W'(Q8_8_MIN);

   logic                     s1_valid;
   logic signed [ACC_W-1:0]  s1_sum;
   logic                     s1_adv_c;
   logic                     s2_adv_c;
   logic signed [ACC_W-1:0]  shifted_c;
   q8_8_t                    s2_data_c;
   logic                     s2_sat_c;
   logic                     sat_fire_c;

   // Stage advance: each stage moves when its slot is free or draining.
   assign s2_adv_c     = !bus.out_valid || bus.out_ready;
   assign s1_adv_c     = !s1_valid || s2_adv_c;
   assign bus.in_ready = s1_adv_c;

   // S1: sign-extended input plus rounding bias; 33 bits cannot overflow.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid <= 1'b0;
         s1_sum   <= '0;
      end else if (s1_adv_c) begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            s1_sum <= ACC_W'(bus.in_data) + RND;
         end
      end
   end

   // S2 combinational: drop 8 fraction bits, then clamp into Q8.8 range.
   assign shifted_c = s1_sum >>> Q_SHIFT;

   always_comb begin
      s2_data_c = shifted_c[Q8_8_W-1:0];
      s2_sat_c  = 1'b0;
      if (shifted_c > S2_HI) begin
         s2_data_c = Q8_8_MAX;
         s2_sat_c  = 1'b1;
      end else if (shifted_c < S2_LO) begin
         s2_data_c = Q8_8_MIN;
         s2_sat_c  = 1'b1;
      end
   end

   // S2 register: holds its word while downstream stalls.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_sat   <= 1'b0;
      end else if (s2_adv_c) begin
         bus.out_valid <= s1_valid;
         if (s1_valid) begin
            bus.out_data <= s2_data_c;
            bus.out_sat  <= s2_sat_c;
         end
      end
   end

   assign sat_fire_c = bus.out_valid && bus.out_ready && bus.out_sat;

   // Saturation counter: clear has priority, increments stop at all-ones.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sat_count <= '0;
      end else if (clear_count) begin
         sat_count <= '0;
      end else if (sat_fire_c && (sat_count != '1)) begin
         sat_count <= sat_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_requant_q16_16_to_q8_8.sv
// Directed bench for requant_q16_16_to_q8_8: one instance per rounding mode,
// both fed the same input stream; mode 0 instance always drains.
module tb_requant_q16_16_to_q8_8;
   import npu_fixed_pkg::*;

   logic        clk;
   logic        rst;
   logic        clear_count;
   logic [15:0] sat_count1;
   logic [15:0] sat_count0;

   int total = 0;
   int bad   = 0;

   requant_q16_16_to_q8_8_if b1 ();
   requant_q16_16_to_q8_8_if b0 ();

   assign b0.in_valid  = b1.in_valid;
   assign b0.in_data   = b1.in_data;
   assign b0.out_ready = 1'b1;

   requant_q16_16_to_q8_8 #(.ROUND_MODE(1)) dut1 (
      .clk         (clk),
      .rst         (rst),
      .bus         (b1.slave),
      .clear_count (clear_count),
      .sat_count   (sat_count1)
   );

   requant_q16_16_to_q8_8 #(.ROUND_MODE(0)) dut0 (
      .clk         (clk),
      .rst         (rst),
      .bus         (b0.slave),
      .clear_count (clear_count),
      .sat_count   (sat_count0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Single isolated word with out_ready high: result visible two edges later.
   task automatic one(input string tag, input logic [31:0] d,
                      input logic [15:0] e1, input logic e1s,
                      input logic chk0, input logic [15:0] e0);
      chk({tag, "_in_ready"}, 16'(b1.in_ready), 16'd1);
      b1.in_valid = 1'b1;
      b1.in_data  = d;
      @(negedge clk);
      b1.in_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_valid"}, 16'(b1.out_valid), 16'd1);
      chk({tag, "_data"},  b1.out_data, e1);
      chk({tag, "_sat"},   16'(b1.out_sat), 16'(e1s));
      if (chk0) begin
         chk({tag, "_m0_data"}, b0.out_data, e0);
         chk({tag, "_m0_sat"},  16'(b0.out_sat), 16'd0);
      end
      @(negedge clk);
   endtask

   logic [31:0] bp_in  [5];
   logic [15:0] bp_exp [5];

   initial begin
      int idx;
      int oidx;
      logic acc;

      for (int i = 0; i < 5; i++) begin
         bp_in[i]  = 32'(i + 1) << 16;
         bp_exp[i] = 16'(i + 1) << 8;
      end

      rst         = 1'b0;
      clear_count = 1'b0;
      b1.in_valid = 1'b0;
      b1.in_data  = '0;
      b1.out_ready = 1'b1;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_out_valid", 16'(b1.out_valid), 16'd0);
      chk("rst_out_data",  b1.out_data, 16'h0000);
      chk("rst_out_sat",   16'(b1.out_sat), 16'd0);
      chk("rst_sat_count", sat_count1, 16'h0000);
      rst = 1'b1;
      #1;
      chk("rel_in_ready", 16'(b1.in_ready), 16'd1);

      // Back-to-back pair, two-cycle latency
      b1.in_valid = 1'b1;
      b1.in_data  = 32'h0001_0000;
      @(negedge clk);
      chk("b2b_s1_only", 16'(b1.out_valid), 16'd0);
      b1.in_data  = 32'h0000_8000;
      @(negedge clk);
      b1.in_valid = 1'b0;
      chk("b2b0_valid", 16'(b1.out_valid), 16'd1);
      chk("b2b0_data",  b1.out_data, 16'h0100);
      chk("b2b0_sat",   16'(b1.out_sat), 16'd0);
      @(negedge clk);
      chk("b2b1_valid", 16'(b1.out_valid), 16'd1);
      chk("b2b1_data",  b1.out_data, 16'h0080);
      chk("b2b1_sat",   16'(b1.out_sat), 16'd0);
      @(negedge clk);
      chk("b2b_drained", 16'(b1.out_valid), 16'd0);

      // Rounding in both modes
      one("rnd_pos_half", 32'h0000_0080, 16'h0001, 1'b0, 1'b1, 16'h0000);
      one("rnd_neg_half", 32'hFFFF_FF80, 16'h0000, 1'b0, 1'b1, 16'hFFFF);
      one("rnd_1p5",      32'h0001_8000, 16'h0180, 1'b0, 1'b1, 16'h0180);
      one("rnd_neg1p5",   32'hFFFE_8000, 16'hFE80, 1'b0, 1'b1, 16'hFE80);
      chk("rnd_sat_count", sat_count1, 16'h0000);

      // Saturation edges
      one("sat_below_hi", 32'h007F_FF7F, 16'h7FFF, 1'b0, 1'b1, 16'h7FFF);
      one("sat_hi_edge",  32'h007F_FF80, 16'h7FFF, 1'b1, 1'b1, 16'h7FFF);
      one("sat_maxmax",   32'h3FFF_0001, 16'h7FFF, 1'b1, 1'b0, 16'h0000);
      one("sat_min",      32'h8000_0000, 16'h8000, 1'b1, 1'b0, 16'h0000);
      chk("sat_count_3",  sat_count1, 16'd3);
      chk("sat_count_m0", sat_count0, 16'd2);

      // Backpressure: stall 4 cycles, then drain all 5 words in order
      idx  = 0;
      oidx = 0;
      for (int c = 0; c < 20; c++) begin
         b1.out_ready = (c >= 4);
         b1.in_valid  = (idx < 5);
         b1.in_data   = (idx < 5) ? bp_in[idx] : 32'h0;
         #1;
         if (c == 2 || c == 3) begin
            chk("bp_in_ready_low", 16'(b1.in_ready), 16'd0);
            chk("bp_stall_valid",  16'(b1.out_valid), 16'd1);
            chk("bp_stall_data",   b1.out_data, 16'h0100);
         end
         acc = b1.in_valid && b1.in_ready;
         if (b1.out_valid && b1.out_ready) begin
            if (oidx < 5) chk($sformatf("bp_out%0d", oidx), b1.out_data, bp_exp[oidx]);
            else          chk("bp_extra_word", 16'(b1.out_valid), 16'd0);
            oidx++;
         end
         @(negedge clk);
         if (acc) idx++;
      end
      b1.in_valid  = 1'b0;
      b1.out_ready = 1'b1;
      chk("bp_in_count",  16'(idx),  16'd5);
      chk("bp_out_count", 16'(oidx), 16'd5);

      // Counter clear, including clear coinciding with an increment
      clear_count = 1'b1;
      @(negedge clk);
      clear_count = 1'b0;
      chk("clr_zero", sat_count1, 16'h0000);
      b1.in_valid = 1'b1;
      b1.in_data  = 32'h7FFF_FFFF;
      @(negedge clk);
      @(negedge clk);
      b1.in_valid = 1'b0;
      chk("clr_w0_sat", 16'(b1.out_sat), 16'd1);
      @(negedge clk);
      chk("clr_after_first", sat_count1, 16'd1);
      clear_count = 1'b1;
      @(negedge clk);
      clear_count = 1'b0;
      chk("clr_wins", sat_count1, 16'h0000);
      chk("clr_drained", 16'(b1.out_valid), 16'd0);

      // Drive the counter to its ceiling, then one more saturation
      b1.in_valid = 1'b1;
      b1.in_data  = 32'h7FFF_FFFF;
      repeat (65535) @(negedge clk);
      b1.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("cnt_ceiling", sat_count1, 16'hFFFF);
      one("cnt_over", 32'h8000_0000, 16'h8000, 1'b1, 1'b0, 16'h0000);
      chk("cnt_no_wrap", sat_count1, 16'hFFFF);

      // Reset with two words in flight
      b1.in_valid = 1'b1;
      b1.in_data  = 32'h8000_0000;
      @(negedge clk);
      @(negedge clk);
      b1.in_valid = 1'b0;
      chk("mid_in_flight", 16'(b1.out_valid), 16'd1);
      #1 rst = 1'b0;
      #1;
      chk("mid_rst_valid", 16'(b1.out_valid), 16'd0);
      chk("mid_rst_data",  b1.out_data, 16'h0000);
      chk("mid_rst_sat",   16'(b1.out_sat), 16'd0);
      chk("mid_rst_count", sat_count1, 16'h0000);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rel_in_ready", 16'(b1.in_ready), 16'd1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("mid_no_stale%0d", k), 16'(b1.out_valid), 16'd0);
      end
      one("post_rst", 32'h0002_0000, 16'h0200, 1'b0, 1'b1, 16'h0200);
      chk("post_rst_count", sat_count1, 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
